// File: rtl/coef_block_assembler_if.sv
// Symbol stream from the entropy decoder into coef_block_assembler.
// The producer drives the run/value/EOB symbol and the assembler answers with sym_ready.
interface coef_block_assembler_if;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym_run;
  logic [11:0] sym_val;
  logic        sym_eob;
  logic [1:0]  sym_channel;

  modport master (
    output sym_valid, sym_run, sym_val, sym_eob, sym_channel,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_run, sym_val, sym_eob, sym_channel,
    output sym_ready
  );
endinterface

// File: rtl/coef_block_assembler.sv
// Assembles zigzag run/value symbols into a dequantized 8x8 block for the 2D IDCT,
// publishing each finished block as a one-cycle block_valid pulse spaced by MIN_GAP.
module coef_block_assembler #(
  parameter int MIN_GAP = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  coef_block_assembler_if.slave   sym,
  input  logic                    q_wr_en,
  input  logic [5:0]              q_wr_addr,
  input  logic [7:0]              q_wr_data,
  output logic                    block_valid,
  output logic [1:0]              block_channel,
  output logic [7:0][7:0][11:0]   block_out,
  output logic                    q_err
);

  localparam int HOLD_W = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((MIN_GAP > 1) ? MIN_GAP - 2 : 0);

  // Zigzag index -> natural index (row*8 + col).
  localparam int ZZ_TO_NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic {FILL, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   sym_ready_q, sym_ready_d;
  logic [6:0]             idx_q, idx_d;
  logic                   started_q, started_d;
  logic [1:0]             chan_q, chan_d;
  logic [7:0][7:0][11:0]  work_q, work_d;
  logic [63:0][7:0]       q_tab_q, q_tab_d;
  logic [7:0][7:0][11:0]  block_out_q, block_out_d;
  logic [1:0]             block_channel_q, block_channel_d;
  logic                   block_valid_q, block_valid_d;
  logic                   q_err_q, q_err_d;

  logic                   accept, first_sym, is_write, overrun, done;
  logic [6:0]             p;
  logic [5:0]             nat;
  logic signed [20:0]     prod;
  logic [11:0]            deq;
  logic [7:0][7:0][11:0]  work_wr;

  // Symbol decode and dequantization.
  always_comb begin
    accept    = sym.sym_valid && sym_ready_q;
    p         = idx_q + {3'b000, sym.sym_run};
    overrun   = (p > 7'd63);
    is_write  = accept && !sym.sym_eob && !overrun;
    done      = accept && (sym.sym_eob || (p >= 7'd63));
    first_sym = accept && (idx_q == 7'd0) && !started_q;
    nat       = 6'(ZZ_TO_NAT[p[5:0]]);
    prod      = $signed(sym.sym_val) * $signed({1'b0, q_tab_q[p[5:0]]});
    if (prod > 21'sd2047)       deq = 12'h7ff;
    else if (prod < -21'sd2048) deq = 12'h800;
    else                        deq = prod[11:0];
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    work_wr = work_q;
    if (is_write) work_wr[nat[5:3]][nat[2:0]] = deq;

    q_tab_d = q_tab_q;
    if (q_wr_en) q_tab_d[q_wr_addr] = q_wr_data;

    chan_d          = first_sym ? sym.sym_channel : chan_q;
    started_d       = done ? 1'b0 : (accept ? 1'b1 : started_q);
    idx_d           = done ? 7'd0 : (is_write ? p + 7'd1 : idx_q);
    work_d          = done ? '0 : work_wr;
    block_out_d     = done ? work_wr : block_out_q;
    block_channel_d = done ? chan_d : block_channel_q;
    block_valid_d   = done;
    q_err_d         = accept && !sym.sym_eob && overrun;
  end

  // Spacing FSM: HOLD keeps sym_ready low for MIN_GAP-1 cycles after a completion.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      FILL: begin
        if (done && (MIN_GAP > 1)) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = FILL;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = FILL;
    endcase
    sym_ready_d = (state_d == FILL);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= FILL;
      hold_q          <= '0;
      sym_ready_q     <= 1'b0;
      idx_q           <= 7'd0;
      started_q       <= 1'b0;
      chan_q          <= 2'd0;
      // NOTE: the work array and quant table are flop arrays with defined reset contents
      // (zeros / identity), not RAMs, so they are reset here like any other state.
      work_q          <= '0;
      q_tab_q         <= {64{8'd1}};
      block_out_q     <= '0;
      block_channel_q <= 2'd0;
      block_valid_q   <= 1'b0;
      q_err_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      sym_ready_q     <= sym_ready_d;
      idx_q           <= idx_d;
      started_q       <= started_d;
      chan_q          <= chan_d;
      work_q          <= work_d;
      q_tab_q         <= q_tab_d;
      block_out_q     <= block_out_d;
      block_channel_q <= block_channel_d;
      block_valid_q   <= block_valid_d;
      q_err_q         <= q_err_d;
    end
  end

  assign sym.sym_ready   = sym_ready_q;
  assign block_out       = block_out_q;
  assign block_channel   = block_channel_q;
  assign block_valid     = block_valid_q;
  assign q_err           = q_err_q;

endmodule
